// File: rtl/wb_mem_slave.sv
// wb_mem_slave
//   Wishbone B4 pipelined memory slave. Holds 2^ADDR_WIDTH words of
//   DATA_WIDTH bits. Each accepted request travels through a LATENCY-stage
//   pipeline and is acknowledged exactly LATENCY cycles after acceptance,
//   in acceptance order. Writes commit at the acceptance edge with
//   byte-lane enables. Read data is captured at acceptance.
//
// Ports
//   clk_i            single clock, rising edge
//   rst_i            asynchronous reset, active low
//   wb_adr_i         word address
//   wb_dat_i         write data
//   wb_dat_o         read data (zero outside ack cycles and for write acks)
//   wb_we_i          write enable
//   wb_sel_i         byte lane enables
//   wb_stb_i         strobe
//   wb_cyc_i         cycle; dropping it aborts everything in flight
//   wb_ack_o         acknowledge, one cycle per accepted request
//   wb_stall_o       stall; combinational
//   stall_request_i  test hook: forces wb_stall_o high
//   inject_en_i      test hook: replace read data in ack cycles
//   injected_data_i  test hook: replacement read data
module wb_mem_slave #(
  parameter int ADDR_WIDTH      = 10,
  parameter int DATA_WIDTH      = 32,
  parameter int LATENCY         = 1,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  input  logic                    wb_we_i,
  input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_cyc_i,
  output logic                    wb_ack_o,
  output logic                    wb_stall_o,
  input  logic                    stall_request_i,
  input  logic                    inject_en_i,
  input  logic [DATA_WIDTH-1:0]   injected_data_i
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
  localparam int DEPTH     = 1 << ADDR_WIDTH;

  // Elaboration-time guards on parameter legality.
  if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
    $error("wb_mem_slave: DATA_WIDTH must be a multiple of 8");
  end
  if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
    $error("wb_mem_slave: LATENCY must be in 1..8");
  end
  if (MAX_OUTSTANDING < 1) begin : g_bad_max_outstanding
    $error("wb_mem_slave: MAX_OUTSTANDING must be at least 1");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [CNT_WIDTH-1:0]  outstanding;
  logic [LATENCY-1:0]    pipe_vld;
  logic [LATENCY-1:0]    pipe_we;
  logic [DATA_WIDTH-1:0] pipe_dat [LATENCY];

  logic accept;
  logic ack;

  // Outstanding is zero during reset, so stall follows stall_request_i there.
  assign wb_stall_o = stall_request_i | (outstanding == CNT_WIDTH'(MAX_OUTSTANDING));
  assign accept     = wb_cyc_i & wb_stb_i & ~wb_stall_o;
  assign ack        = pipe_vld[LATENCY-1];
  assign wb_ack_o   = ack;

  always_comb begin
    wb_dat_o = '0;
    if (ack) begin
      if (inject_en_i) begin
        wb_dat_o = injected_data_i;
      end else if (!pipe_we[LATENCY-1]) begin
        wb_dat_o = pipe_dat[LATENCY-1];
      end
    end
  end

  // Memory contents are deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (accept && wb_we_i) begin
      for (int b = 0; b < SEL_WIDTH; b++) begin
        if (wb_sel_i[b]) begin
          mem[wb_adr_i][b*8 +: 8] <= wb_dat_i[b*8 +: 8];
        end
      end
    end
  end

  // Read data rides alongside the valid bit; stage 0 reloads every cycle
  // but only matters when the matching valid bit is set. The read sees the
  // memory as of this edge, so a write accepted one cycle earlier is visible.
  always_ff @(posedge clk_i) begin
    for (int i = LATENCY - 1; i > 0; i--) begin
      pipe_dat[i] <= pipe_dat[i-1];
    end
    pipe_dat[0] <= mem[wb_adr_i];
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pipe_vld    <= '0;
      pipe_we     <= '0;
      outstanding <= '0;
    end else if (!wb_cyc_i) begin
      // Cycle abort: drop everything in flight, no late acks.
      pipe_vld    <= '0;
      pipe_we     <= '0;
      outstanding <= '0;
    end else begin
      for (int i = LATENCY - 1; i > 0; i--) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_we[i]  <= pipe_we[i-1];
      end
      pipe_vld[0] <= accept;
      pipe_we[0]  <= accept & wb_we_i;

      case ({accept, ack})
        2'b10:   outstanding <= outstanding + CNT_WIDTH'(1);
        2'b01:   outstanding <= outstanding - CNT_WIDTH'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: doc/wb_mem_slave.md
WB_MEM_SLAVE -- requirements
Module: wb_mem_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, meaning word-address bits; memory depth is 2^ADDR_WIDTH words.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning word width; legal values are multiples of 8.
REQ-003 SHALL have parameter LATENCY, default 1, meaning cycles from request acceptance to ack; legal range is 1..8.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4, meaning the maximum number of accepted-but-unacked requests; legal range is 1..LATENCY+1.
REQ-005 SHALL have port clk_i, input, width 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_i, input, width 1: asynchronous, active-low reset.
REQ-007 SHALL have port wb_adr_i, input, width ADDR_WIDTH: word address.
REQ-008 SHALL have port wb_dat_i, input, width DATA_WIDTH: write data.
REQ-009 SHALL have port wb_dat_o, output, width DATA_WIDTH: read data.
REQ-010 SHALL have port wb_we_i, input, width 1: write enable.
REQ-011 SHALL have port wb_sel_i, input, width DATA_WIDTH/8: byte lane enables.
REQ-012 SHALL have ports wb_stb_i and wb_cyc_i, inputs, width 1 each: strobe and cycle.
REQ-013 SHALL have ports wb_ack_o and wb_stall_o, outputs, width 1 each: acknowledge and stall.
REQ-014 SHALL have port stall_request_i, input, width 1: forces wb_stall_o high, for test.
REQ-015 SHALL have ports inject_en_i (input, width 1) and injected_data_i (input, width DATA_WIDTH): override of read data, for test.

Function
REQ-016 SHALL implement a Wishbone B4 pipelined slave; a request is accepted in a cycle where wb_cyc_i & wb_stb_i & !wb_stall_o.
REQ-017 SHALL drive wb_stall_o combinationally as stall_request_i | (outstanding == MAX_OUTSTANDING).
REQ-018 SHALL keep an outstanding counter: +1 on accept, -1 on ack, unchanged when both occur in the same cycle.
REQ-019 SHALL commit an accepted write at the acceptance clock edge, updating only the bytes whose wb_sel_i bit is 1.
REQ-020 SHALL capture read data at acceptance, so a read accepted the cycle after a write to the same address returns the new value.
REQ-021 SHALL carry each accepted request through a LATENCY-stage valid/we/data shift register, asserting wb_ack_o for exactly one cycle LATENCY cycles after acceptance, in acceptance order.
REQ-022 SHALL sustain one accept per cycle with back-to-back acks when MAX_OUTSTANDING >= LATENCY+1 and stall_request_i = 0.
REQ-023 SHALL drive wb_dat_o in an ack cycle as follows: injected_data_i if inject_en_i = 1 (sampled that cycle), otherwise the captured read data; writes output 0.
REQ-024 SHALL drive wb_dat_o = 0 in every cycle without ack.
REQ-025 SHALL, when wb_cyc_i = 0, clear all pipeline valid bits and the outstanding counter at the next edge; no ack for aborted requests follows; committed writes persist.
REQ-026 SHALL ignore wb_stb_i while wb_cyc_i = 0.
REQ-027 SHALL not let stall_request_i asserted mid-burst cancel or delay acks already in flight.

Reset
REQ-028 SHALL, while rst_i = 0, immediately force wb_ack_o = 0, wb_dat_o = 0, outstanding = 0, and all pipeline valid bits = 0.
REQ-029 SHALL drive wb_stall_o = stall_request_i during reset.
REQ-030 SHALL not reset memory contents.
REQ-031 SHALL produce no ack after reset release for requests in flight when reset asserted.

Verification
REQ-032 SHALL be verified with LATENCY=1: write 0xDEADBEEF at address 5 with sel=0xF, then read address 5 -> ack 1 cycle after each accept; read returns 0xDEADBEEF.
REQ-033 SHALL be verified for byte lanes: write 0xFFFFFFFF, then write 0x00000000 with sel=0x2, then read -> 0xFFFF00FF.
REQ-034 SHALL be verified with LATENCY=3, MAX_OUTSTANDING=2 and 4 back-to-back reads -> stall high after 2 accepts, 4 in-order acks, each 3 cycles after its accept.
REQ-035 SHALL be verified for cyc abort: drop wb_cyc_i with 2 requests outstanding -> no acks; counter 0; next request accepted immediately.
REQ-036 SHALL be verified for stall and injection: stall_request_i=1 with stb high for 3 cycles -> no accept; then inject_en_i=1 with injected_data_i=0x12345678 on a read -> wb_dat_o=0x12345678 on ack.
REQ-037 SHALL be verified for reset mid-operation: rst_i low with 1 request in flight -> ack and dat_o 0 immediately; no ack after release.
